// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready handshakes and a pass-through tag.
// The log2(WIDTH) mux levels are spread evenly over STAGES register stages.
module shift_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [1:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int unsigned LVLS = $clog2(WIDTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [LVLS-1:0]  amt;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } stage_t;

    logic   [STAGES-1:0] vld_q;
    stage_t              stg_q   [STAGES];
    stage_t              src     [STAGES];
    stage_t              nxt     [STAGES];
    logic   [STAGES-1:0] src_vld;
    logic   [STAGES:0]   adv;
    logic                unused_b;

    assign unused_b = ^dataB[WIDTH-1:LVLS];

    // One mux level: shift by 2^lvl in the direction/fill selected by o.
    function automatic logic [WIDTH-1:0] lvl_shift(input logic [WIDTH-1:0] x,
                                                   input logic [1:0]       o,
                                                   input int unsigned      lvl);
        int unsigned      sh;
        logic [WIDTH-1:0] r;
        sh = 32'd1 << lvl;
        case (o)
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = WIDTH'($signed(x) >>> sh);
            default: r = (x << sh) | (x >> (WIDTH - sh));
        endcase
        return r;
    endfunction

    // Ready ripples back from the consumer; an empty stage can always take a new op.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            adv[k] = !vld_q[k] || adv[k+1];
        end
        in_ready = adv[0] && !flush && !reset;
    end

    always_comb begin
        src[0]      = '0;
        src[0].data = dataA;
        src[0].amt  = dataB[LVLS-1:0];
        src[0].op   = op;
        src[0].tag  = in_tag;
        src_vld     = '0;
        src_vld[0]  = in_valid && in_ready;
        for (int k = 1; k < int'(STAGES); k++) begin
            src[k]     = stg_q[k-1];
            src_vld[k] = vld_q[k-1];
        end
    end

    // Level i belongs to stage floor(i*STAGES/LVLS).
    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            nxt[k] = src[k];
            for (int i = 0; i < int'(LVLS); i++) begin
                if (((i * int'(STAGES)) / int'(LVLS) == k) && src[k].amt[i]) begin
                    nxt[k].data = lvl_shift(nxt[k].data, src[k].op, i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (flush) begin
                    vld_q[k] <= 1'b0;
                end else if (adv[k]) begin
                    vld_q[k] <= src_vld[k];
                end
                if (!flush && adv[k] && src_vld[k]) begin
                    stg_q[k] <= nxt[k];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign dataOut   = stg_q[STAGES-1].data;
    assign out_tag   = stg_q[STAGES-1].tag;
    assign busy      = |vld_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed handshake/flush/reset scenarios on a STAGES=2 instance plus
// a randomized scoreboard and a full amount sweep on STAGES=1 and STAGES=LVLS instances.
module tb_shift_pipe;
    localparam int W  = 32;
    localparam int TW = 4;
    localparam int LV = 5;
    localparam int EW = W + TW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, flush;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]  dataA, dataB, dataOut;
    logic [1:0]    op;
    logic [TW-1:0] in_tag, out_tag;

    logic          sw_valid, sw_ordy;
    logic [W-1:0]  sw_a, sw_b;
    logic [1:0]    sw_op;
    logic [TW-1:0] sw_tag;
    logic          s1_ir, s1_ov, s1_busy, s5_ir, s5_ov, s5_busy;
    logic [W-1:0]  s1_d, s5_d;
    logic [TW-1:0] s1_t, s5_t;

    int n_pass = 0;
    int n_chk  = 0;
    logic [EW-1:0] q [3][$];

    shift_pipe #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .dataA(dataA), .dataB(dataB), .op(op), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .dataOut(dataOut), .out_tag(out_tag), .busy(busy));

    shift_pipe #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) u_s1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(sw_valid), .in_ready(s1_ir),
        .dataA(sw_a), .dataB(sw_b), .op(sw_op), .in_tag(sw_tag), .out_valid(s1_ov),
        .out_ready(sw_ordy), .dataOut(s1_d), .out_tag(s1_t), .busy(s1_busy));

    shift_pipe #(.WIDTH(W), .STAGES(LV), .TAG_W(TW)) u_s5 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(sw_valid), .in_ready(s5_ir),
        .dataA(sw_a), .dataB(sw_b), .op(sw_op), .in_tag(sw_tag), .out_valid(s5_ov),
        .out_ready(sw_ordy), .dataOut(s5_d), .out_tag(s5_t), .busy(s5_busy));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Reference result, defined bit by bit from where each output bit comes from.
    function automatic logic [W-1:0] shift_ref(input logic [W-1:0] a, input int amt, input logic [1:0] o);
        logic [W-1:0] r;
        for (int j = 0; j < W; j++) begin
            case (o)
                2'd0:    r[j] = (j >= amt) ? a[j-amt] : 1'b0;
                2'd1:    r[j] = (j + amt < W) ? a[j+amt] : 1'b0;
                2'd2:    r[j] = (j + amt < W) ? a[j+amt] : a[W-1];
                default: r[j] = a[(j - amt + W) % W];
            endcase
        end
        return r;
    endfunction

    // Handshakes seen at the negedge complete at the following posedge.
    task automatic sb_step(input int idx, input logic iv, input logic ir, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [1:0] o, input logic [TW-1:0] t,
                           input logic ov, input logic ordy, input logic [W-1:0] dout,
                           input logic [TW-1:0] otag);
        logic [EW-1:0] e;
        if (ov && ordy) begin
            check($sformatf("sb%0d_expected_any", idx), 64'(q[idx].size() != 0), 64'd1);
            if (q[idx].size() != 0) begin
                e = q[idx].pop_front();
                check($sformatf("sb%0d_data", idx), 64'(dout), 64'(e[W-1:0]));
                check($sformatf("sb%0d_tag", idx), 64'(otag), 64'(e[EW-1:W]));
            end
        end
        if (iv && ir) q[idx].push_back({t, shift_ref(a, int'(b[LV-1:0]), o)});
        if (flush) q[idx].delete();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            sb_step(0, in_valid, in_ready, dataA, dataB, op, in_tag, out_valid, out_ready, dataOut, out_tag);
            sb_step(1, sw_valid, s1_ir, sw_a, sw_b, sw_op, sw_tag, s1_ov, sw_ordy, s1_d, s1_t);
            sb_step(2, sw_valid, s5_ir, sw_a, sw_b, sw_op, sw_tag, s5_ov, sw_ordy, s5_d, s5_t);
        end
    end

    always @(posedge reset) begin
        for (int i = 0; i < 3; i++) q[i].delete();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic op_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] o, input logic [TW-1:0] t, input logic [W-1:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dataA     = a;
        dataB     = b;
        op        = o;
        in_tag    = t;
        tick();
        in_valid = 1'b0;
        tick();
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_data"}, 64'(dataOut), 64'(exp));
        check({name, "_tag"}, 64'(out_tag), 64'(t));
    endtask

    initial begin
        logic         acc;
        logic [W-1:0] held;
        bit           have;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        dataA = '0; dataB = '0; op = 2'd0; in_tag = '0;
        sw_valid = 1'b0; sw_ordy = 1'b1; sw_a = '0; sw_b = '0; sw_op = 2'd0; sw_tag = '0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_data", 64'(dataOut), 64'd0);
        repeat (2) tick();
        reset = 1'b0;
        #1 check("rel_in_ready", 64'(in_ready), 64'd1);

        // Latency: accepted at edge n, visible after edge n+1.
        in_valid = 1'b1; dataA = 32'h0000_0001; dataB = 32'd31; op = 2'd0; in_tag = 4'h5;
        tick();
        in_valid = 1'b0;
        check("lat_early", 64'(out_valid), 64'd0);
        tick();
        check("lat_valid", 64'(out_valid), 64'd1);
        check("sll31_data", 64'(dataOut), 64'h8000_0000);
        check("sll31_tag", 64'(out_tag), 64'h5);

        op_check("sra4", 32'h8000_0000, 32'd4, 2'd2, 4'h1, 32'hF800_0000);
        op_check("srl4", 32'h8000_0000, 32'd4, 2'd1, 4'h2, 32'h0800_0000);
        op_check("rol1", 32'h8000_0001, 32'd1, 2'd3, 4'h3, 32'h0000_0003);
        op_check("sra_b24", 32'h8000_0000, 32'h0000_0024, 2'd2, 4'h4, 32'hF800_0000);
        op_check("rol0", 32'hA5C3_0F96, 32'h0000_0020, 2'd3, 4'h6, 32'hA5C3_0F96);
        op_check("sll0", 32'h1234_5678, 32'd0, 2'd0, 4'h7, 32'h1234_5678);

        // Back-to-back ops, tags 0..7, one result per cycle.
        for (int k = 0; k <= 8; k++) begin
            in_valid = (k < 8);
            dataA = $urandom; dataB = $urandom; op = 2'($urandom); in_tag = 4'(k);
            tick();
            if (k >= 1) begin
                check($sformatf("b2b_valid%0d", k - 1), 64'(out_valid), 64'd1);
                check($sformatf("b2b_tag%0d", k - 1), 64'(out_tag), 64'(k - 1));
            end
        end

        // Stall: fill, hold out_ready low, output must stay stable.
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 4'h8;
        dataA = $urandom; dataB = $urandom; op = 2'($urandom);
        have = 0; held = '0;
        for (int k = 0; k < 6; k++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                in_tag = in_tag + 4'd1; dataA = $urandom; dataB = $urandom; op = 2'($urandom);
            end
            if (out_valid) begin
                if (!have) begin held = dataOut; have = 1; end
                else check($sformatf("stall_hold%0d", k), 64'(dataOut), 64'(held));
            end
        end
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        drain("stall_drain", 20);
        check("stall_sb_empty", 64'(q[0].size()), 64'd0);

        // Flush with two ops in flight and a new op offered.
        in_valid = 1'b1; dataA = $urandom; dataB = $urandom; op = 2'd1; in_tag = 4'h1;
        tick();
        in_tag = 4'h2;
        tick();
        in_tag = 4'h3; flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        check("flush_busy_pre", 64'(busy), 64'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        check("flush_no_accept", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0; in_valid = 1'b1; dataA = 32'hDEAD_BEEF; dataB = 32'd0; op = 2'd0;
        repeat (3) tick();
        in_valid = 1'b0;
        check("mid_stall_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(dataOut), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        tick();
        reset = 1'b0; out_ready = 1'b1;
        #1 check("arst_rel_ready", 64'(in_ready), 64'd1);

        // Random traffic with backpressure and occasional flush.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            dataA     = $urandom; dataB = $urandom; op = 2'($urandom); in_tag = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drain("rand_drain", 20);
        check("rand_sb_empty", 64'(q[0].size()), 64'd0);

        // Every amount for every op on the shallowest and deepest pipelines.
        for (int o = 0; o < 4; o++) begin
            for (int a = 0; a < W; a++) begin
                sw_valid = 1'b1;
                sw_a     = (a % 2 == 1) ? 32'($urandom) : {1'b1, 31'($urandom)};
                sw_b     = {27'($urandom), 5'(a)};
                sw_op    = 2'(o);
                sw_tag   = 4'(a);
                tick();
            end
        end
        sw_valid = 1'b0;
        repeat (LV + 3) tick();
        check("sweep1_busy", 64'(s1_busy), 64'd0);
        check("sweep5_busy", 64'(s5_busy), 64'd0);
        check("sweep1_sb_empty", 64'(q[1].size()), 64'd0);
        check("sweep5_sb_empty", 64'(q[2].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
